// File: rtl/param_fifo.sv
// Single-clock synchronous FIFO with registered read, occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module param_fifo #(
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 8,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      pop,
    input  logic                      err_clr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL    = (AW+1)'(ALMOST_FULL);
    localparam logic [AW:0] AE_LVL    = (AW+1)'(ALMOST_EMPTY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic [AW:0]           count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  data_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic pop_ok;
    logic push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset so it maps onto plain distributed/block memory.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                data_out_reg <= mem[rd_ptr_reg];
            end
            data_valid_reg <= pop_ok;
            count_reg      <= count_next;

            // A new error in the same cycle as err_clr keeps the flag set.
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (pop && !pop_ok) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign data_out     = data_out_reg;
    assign data_valid   = data_valid_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign full         = (count_reg == DEPTH_LVL);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_LVL);
    assign almost_empty = (count_reg <= AE_LVL);

endmodule
